// File: rtl/memgame_pkg.sv
// Shared types and helpers for the memory-game control blocks.
package memgame_pkg;

  typedef enum logic [2:0] {IDLE, SHOW, WAIT, OVER, WON} state_e;

  localparam int DEF_NUM_LEVELS  = 4;
  localparam int DEF_WIN_STREAK  = 2;
  localparam int DEF_MAX_LIVES   = 3;
  localparam int DEF_SHOW_CYCLES = 4;

  // Bit width needed to encode v distinct values, never less than 1.
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/level_ctrl_disp_timer.sv
// Loadable down-counter timing the show-pattern phase; tc flags the last count.
module disp_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         tc
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                       cnt_d = '0;
    else if (load)                 cnt_d = load_val;
    else if (dec && cnt_q != '0)   cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tc = (cnt_q == W'(1));

endmodule

// File: rtl/level_ctrl.sv
// Level-progression controller: show/answer loop, streak, lives, win/lose.
// Build option: define LEVEL_DEMOTE_EN to drop one level on a non-fatal wrong answer.
module level_ctrl
  import memgame_pkg::*;
#(
  parameter int NUM_LEVELS  = DEF_NUM_LEVELS,
  parameter int WIN_STREAK  = DEF_WIN_STREAK,
  parameter int MAX_LIVES   = DEF_MAX_LIVES,
  parameter int SHOW_CYCLES = DEF_SHOW_CYCLES
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  en,
  input  logic                                  restart,
  input  logic                                  ans_valid,
  input  logic                                  ans_correct,
  output logic                                  ans_ready,
  output logic                                  disp,
  output logic [clog2_min1(NUM_LEVELS)-1:0]     level,
  output logic [clog2_min1(MAX_LIVES+1)-1:0]    lives,
  output logic                                  level_up,
  output logic                                  game_over,
  output logic                                  game_won
);

  localparam int LVL_W  = clog2_min1(NUM_LEVELS);
  localparam int LIFE_W = clog2_min1(MAX_LIVES + 1);
  localparam int STK_W  = clog2_min1(WIN_STREAK + 1);
  localparam int TMR_W  = clog2_min1(SHOW_CYCLES + 1);

  state_e              state_q, state_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic [LIFE_W-1:0]   lives_q, lives_d;
  logic [STK_W-1:0]    streak_q, streak_d;
  logic                level_up_q, level_up_d;
  logic                tmr_load, tmr_clr, tmr_dec, tmr_tc;

  disp_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clr      (tmr_clr),
    .load     (tmr_load),
    .load_val (TMR_W'(SHOW_CYCLES)),
    .dec      (tmr_dec),
    .tc       (tmr_tc)
  );

  assign tmr_dec = (state_q == SHOW) && en && !restart;

  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
    lives_d    = lives_q;
    streak_d   = streak_q;
    level_up_d = 1'b0;
    tmr_load   = 1'b0;
    tmr_clr    = 1'b0;
    if (restart) begin
      state_d  = IDLE;
      level_d  = '0;
      lives_d  = LIFE_W'(MAX_LIVES);
      streak_d = '0;
      tmr_clr  = 1'b1;
    end else if (en) begin
      unique case (state_q)
        IDLE: begin
          state_d  = SHOW;
          tmr_load = 1'b1;
        end
        SHOW: if (tmr_tc) state_d = WAIT;
        WAIT: if (ans_valid) begin
          if (ans_correct) begin
            if (int'(streak_q) + 1 < WIN_STREAK) begin
              streak_d = streak_q + 1'b1;
              state_d  = SHOW;
              tmr_load = 1'b1;
            end else begin
              streak_d = '0;
              if (int'(level_q) == NUM_LEVELS - 1) begin
                state_d = WON;
              end else begin
                level_d    = level_q + 1'b1;
                level_up_d = 1'b1;
                state_d    = SHOW;
                tmr_load   = 1'b1;
              end
            end
          end else begin
            streak_d = '0;
            if (lives_q == LIFE_W'(1)) begin
              lives_d = '0;
              state_d = OVER;
            end else begin
              lives_d  = lives_q - 1'b1;
              state_d  = SHOW;
              tmr_load = 1'b1;
`ifdef LEVEL_DEMOTE_EN
              if (level_q != '0) level_d = level_q - 1'b1;
`endif
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      level_q    <= '0;
      lives_q    <= LIFE_W'(MAX_LIVES);
      streak_q   <= '0;
      level_up_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      lives_q    <= lives_d;
      streak_q   <= streak_d;
      level_up_q <= level_up_d;
    end
  end

  assign ans_ready = (state_q == WAIT) && en;
  assign disp      = (state_q == SHOW);
  assign level     = level_q;
  assign lives     = lives_q;
  assign level_up  = level_up_q;
  assign game_over = (state_q == OVER);
  assign game_won  = (state_q == WON);

endmodule

// File: tb/tb_level_ctrl.sv
// Self-checking bench for level_ctrl with default parameters (4 levels, streak 2, 3 lives, 4 show cycles).
module tb_level_ctrl;

`ifdef LEVEL_DEMOTE_EN
  localparam bit DEMOTE = 1'b1;
`else
  localparam bit DEMOTE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, en, restart, ans_valid, ans_correct;
  logic       ans_ready, disp, level_up, game_over, game_won;
  logic [1:0] level, lives;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       correct;
    logic [1:0] lvl;
    logic [1:0] lives;
    logic       lu;
    logic       over;
    logic       won;
  } vec_t;

  vec_t sb[$];
  vec_t t_win[8];
  vec_t t_lose[3];
  vec_t t_mix[4];
  vec_t t_dem[4];

  level_ctrl dut (
    .clk(clk), .reset(reset), .en(en), .restart(restart),
    .ans_valid(ans_valid), .ans_correct(ans_correct), .ans_ready(ans_ready),
    .disp(disp), .level(level), .lives(lives), .level_up(level_up),
    .game_over(game_over), .game_won(game_won)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_round(input vec_t v);
    vec_t e;
    int   n;
    n = 0;
    while (!ans_ready && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (!ans_ready) begin
      errors++;
      $display("FAIL ready_timeout: got 0 expected 1");
      return;
    end
    ans_valid   = 1'b1;
    ans_correct = v.correct;
    sb.push_back(v);
    step();
    ans_valid = 1'b0;
    e = sb.pop_front();
    chk("level", level, e.lvl);
    chk("lives", lives, e.lives);
    chk("level_up", level_up, e.lu);
    chk("game_over", game_over, e.over);
    chk("game_won", game_won, e.won);
    chk("disp_after_ans", disp, !(e.over || e.won));
    chk("ready_after_ans", ans_ready, 1'b0);
    if (e.lu) begin
      step();
      chk("level_up_one_cycle", level_up, 1'b0);
    end
  endtask

  task automatic do_restart();
    restart = 1'b1;
    step();
    restart = 1'b0;
    chk("rst_level", level, 0);
    chk("rst_lives", lives, 3);
    chk("rst_disp", disp, 0);
    chk("rst_over", game_over, 0);
    chk("rst_won", game_won, 0);
  endtask

  initial begin
    int cnt;
    // {correct, level, lives, level_up, over, won}
    t_win[0] = {1'b1, 2'd0, 2'd3, 1'b0, 1'b0, 1'b0};
    t_win[1] = {1'b1, 2'd1, 2'd3, 1'b1, 1'b0, 1'b0};
    t_win[2] = {1'b1, 2'd1, 2'd3, 1'b0, 1'b0, 1'b0};
    t_win[3] = {1'b1, 2'd2, 2'd3, 1'b1, 1'b0, 1'b0};
    t_win[4] = {1'b1, 2'd2, 2'd3, 1'b0, 1'b0, 1'b0};
    t_win[5] = {1'b1, 2'd3, 2'd3, 1'b1, 1'b0, 1'b0};
    t_win[6] = {1'b1, 2'd3, 2'd3, 1'b0, 1'b0, 1'b0};
    t_win[7] = {1'b1, 2'd3, 2'd3, 1'b0, 1'b0, 1'b1};
    t_lose[0] = {1'b0, 2'd0, 2'd2, 1'b0, 1'b0, 1'b0};
    t_lose[1] = {1'b0, 2'd0, 2'd1, 1'b0, 1'b0, 1'b0};
    t_lose[2] = {1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0};
    t_mix[0] = {1'b1, 2'd0, 2'd3, 1'b0, 1'b0, 1'b0};
    t_mix[1] = {1'b0, 2'd0, 2'd2, 1'b0, 1'b0, 1'b0};
    t_mix[2] = {1'b1, 2'd0, 2'd2, 1'b0, 1'b0, 1'b0};
    t_mix[3] = {1'b1, 2'd1, 2'd2, 1'b1, 1'b0, 1'b0};
    t_dem[0] = {1'b1, 2'd0, 2'd3, 1'b0, 1'b0, 1'b0};
    t_dem[1] = {1'b1, 2'd1, 2'd3, 1'b1, 1'b0, 1'b0};
    t_dem[2] = {1'b0, (DEMOTE ? 2'd0 : 2'd1), 2'd2, 1'b0, 1'b0, 1'b0};
    t_dem[3] = {1'b0, (DEMOTE ? 2'd0 : 2'd1), 2'd1, 1'b0, 1'b0, 1'b0};

    reset = 1'b1; en = 1'b0; restart = 1'b0; ans_valid = 1'b0; ans_correct = 1'b0;
    step(); step();
    reset = 1'b0;
    chk("reset_level", level, 0);
    chk("reset_lives", lives, 3);
    chk("reset_disp", disp, 0);
    chk("reset_ready", ans_ready, 0);
    chk("reset_flags", {level_up, game_over, game_won}, 0);

    // IDLE -> SHOW on the first enabled edge; disp held for exactly 4 cycles
    en = 1'b1;
    step();
    cnt = 0;
    while (disp && cnt < 20) begin
      cnt++;
      step();
    end
    chk("show_len", cnt, 4);
    chk("ready_in_wait", ans_ready, 1);

    foreach (t_win[i]) do_round(t_win[i]);
    ans_valid = 1'b1; ans_correct = 1'b0;
    step(); step();
    ans_valid = 1'b0;
    chk("won_hold_level", level, 3);
    chk("won_hold_lives", lives, 3);
    chk("won_hold_flag", game_won, 1);
    do_restart();

    foreach (t_lose[i]) do_round(t_lose[i]);
    ans_valid = 1'b1; ans_correct = 1'b1;
    step(); step(); step();
    ans_valid = 1'b0;
    chk("over_hold_lives", lives, 0);
    chk("over_hold_flag", game_over, 1);
    chk("over_no_ready", ans_ready, 0);
    do_restart();

    foreach (t_mix[i]) do_round(t_mix[i]);
    do_restart();

    foreach (t_dem[i]) do_round(t_dem[i]);
    do_restart();

    // en low for 3 cycles mid-SHOW stretches disp to 7; answers during SHOW ignored
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      en = !(i >= 2 && i < 5);
      ans_valid = 1'b1; ans_correct = 1'b0;
      step();
      if (disp) cnt++;
      else break;
    end
    ans_valid = 1'b0; en = 1'b1;
    chk("stretched_show_len", cnt, 7);
    chk("show_ans_ignored", lives, 3);
    chk("wait_ready", ans_ready, 1);
    en = 1'b0;
    #1;
    chk("wait_ready_gated", ans_ready, 0);
    ans_valid = 1'b1; ans_correct = 1'b0;
    step();
    ans_valid = 1'b0;
    chk("gated_ans_ignored", lives, 3);
    en = 1'b1;
    #1;
    chk("still_wait", ans_ready, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("wait_reset_disp", disp, 0);
    chk("wait_reset_ready", ans_ready, 0);
    chk("wait_reset_level", level, 0);
    chk("wait_reset_lives", lives, 3);
    chk("wait_reset_flags", {level_up, game_over, game_won}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/level_ctrl.md
Name: level_ctrl

Overview:
Parametrised level-progression controller for the memory game; replaces the fixed 2-bit, 4-level chooser.
- Sequences the show-pattern / wait-for-answer loop.
- Counts consecutive correct answers and advances the level after a configurable streak.
- Tracks remaining lives; flags game over or game won.
- Sits between the answer checker (upstream) and the pattern display / seven-segment status logic (downstream).

Parameters:
NUM_LEVELS, 4, number of levels (>=2); level runs 0..NUM_LEVELS-1
WIN_STREAK, 2, consecutive correct answers required to advance one level (>=1)
MAX_LIVES, 3, wrong answers tolerated before game over (>=1)
SHOW_CYCLES, 4, clock cycles disp is held high per round (>=1)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
en  in  1  run enable; 0 pauses the game
restart  in  1  re-initialise game to IDLE, same values as reset, lower priority than reset
ans_valid  in  1  answer strobe from checker, one cycle
ans_correct  in  1  answer result, qualified by ans_valid
ans_ready  out  1  high while an answer is accepted
disp  out  1  show-pattern request
level  out  LVL_W  current level; LVL_W = max(1, clog2(NUM_LEVELS))
lives  out  LIFE_W  remaining lives; LIFE_W = clog2(MAX_LIVES+1)
level_up  out  1  one-cycle pulse on level advance
game_over  out  1  held high in OVER
game_won  out  1  held high in WON

Behaviour:
- One clock (clk); reset is synchronous and active-high.
- Reset values: state IDLE, level=0, lives=MAX_LIVES, streak=0, timer=0, and all 1-bit outputs 0.
- Priority: reset > restart > en gating > state logic.
- States:
  - IDLE: when en=1, load timer=SHOW_CYCLES and go to SHOW.
  - SHOW: disp=1. Timer decrements each enabled cycle. When timer==1 on an enabled cycle, go to WAIT. disp is high exactly SHOW_CYCLES enabled cycles.
  - WAIT: ans_ready=en. An answer is accepted when ans_valid && ans_ready; the decision is registered next cycle.
  - OVER / WON: terminal. Flags are held. Only restart or reset leaves.
- Correct answer:
  - If streak+1 < WIN_STREAK: streak+=1, go to SHOW.
  - Otherwise streak=0. If level==NUM_LEVELS-1, go to WON (level held). Else level+=1, level_up=1 for one cycle, go to SHOW.
- Wrong answer:
  - streak=0, lives-=1.
  - If lives was 1, lives=0 and go to OVER. Else replay the same level (go to SHOW).
- Every entry into SHOW reloads timer=SHOW_CYCLES.
- ans_valid outside WAIT, or while en=0, is ignored with no side effects.
- en=0 in SHOW or WAIT freezes state and timer. disp keeps its value; ans_ready=0.
- restart mid-round, including during SHOW, returns to IDLE with reset values next cycle.
- No arithmetic wrap: level saturates at NUM_LEVELS-1 via WON; lives never go below 0.

Optional Feature:
LEVEL_DEMOTE_EN
- Defined: a wrong answer that does not end the game also decrements level, saturating at 0. level_up is not asserted on demotion.
- Undefined: a wrong answer never changes level.
- Lives accounting is identical in both builds.

Decomposition:
- Shared package memgame_pkg: state enum (IDLE, SHOW, WAIT, OVER, WON), a clog2-with-min-1 width helper function, and default parameter constants.
- Sub-module disp_timer: loadable down-counter with enable, exposing a terminal-count flag. The level_ctrl FSM instantiates it for the SHOW phase.

Test Plan:
1. Reset, then en=1 -> IDLE to SHOW next cycle; disp high exactly 4 cycles; then ans_ready=1; level=0, lives=3.
2. Two correct answers -> level 0->1, level_up pulses once, streak clears. Six correct answers total -> level 3. Two more correct answers -> game_won=1, level stays 3.
3. Three wrong answers -> lives 3->2->1->0, game_over=1. Further ans_valid pulses ignored; restart -> IDLE with lives=3, level=0.
4. Correct, wrong, correct at level 0 -> level still 0 (streak reset by the wrong answer), lives=2.
5. en=0 for 3 cycles mid-SHOW -> disp stretched to 7 cycles total. ans_valid pulsed during SHOW is ignored. Reset asserted in WAIT -> all outputs at reset values next cycle.
6. With LEVEL_DEMOTE_EN: reach level 1, one wrong answer -> level=0, lives=2. Another wrong answer at level 0 -> level stays 0, lives=1.
